dili_gs_butterfly: RTL
======================

DILI_GS_BUTTERFLY -- requirements
Module: dili_gs_butterfly

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, coefficient port width.
REQ-002 SHALL have parameter Q, default 8380417, Dilithium modulus.
REQ-003 SHALL have parameter QINV, default 58728449, q^-1 mod 2^32 for Montgomery reduction.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  input operand triple valid.
REQ-007 SHALL have port ready_o  output  1  block accepts the operand triple this cycle.
REQ-008 SHALL have ports a_i, b_i  input  DATA_WIDTH  coefficients, unsigned, legal range [0,Q).
REQ-009 SHALL have port zeta_i  input  DATA_WIDTH  twiddle in Montgomery domain (zeta*2^32 mod Q), range [0,Q).
REQ-010 SHALL have port valid_o  output  1  result pair valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the result pair.
REQ-012 SHALL have ports a_o, b_o  output  DATA_WIDTH  results, range [0,Q).

Function
REQ-013 SHALL compute the inverse-NTT Gentleman-Sande butterfly: a_o = (a+b) mod Q; b_o = ((a-b) mod Q) * zeta * 2^-32 mod Q.
REQ-014 SHALL transfer input on valid_i && ready_o; SHALL transfer output on valid_o && ready_i.
REQ-015 SHALL be a 4-stage pipeline: S1 modular add/sub, S2 64-bit product diff*zeta, S3 t = low32(p)*QINV (low 32 bits), S4 r = (p - t*Q)>>32 then +Q if negative.
REQ-016 SHALL present results 4 cycles after acceptance when ready_i is held high; throughput one pair per cycle.
REQ-017 SHALL use a single global advance enable en = !valid_o || ready_i; all stages and per-stage valid bits update only when en.
REQ-018 SHALL drive ready_o = en (combinational from ready_i and valid_o only, never from valid_i).
REQ-019 SHALL hold a_o, b_o, valid_o stable while valid_o && !ready_i.
REQ-020 SHALL carry a_o through S2-S4 alongside b_o so both results emerge in the same cycle.
REQ-021 SHALL perform add/sub wrap with a single conditional correction: sum>=Q -> sum-Q; a<b -> a-b+Q.
REQ-022 SHALL neither lose nor duplicate a triple under any valid_i/ready_i pattern, including ready_i toggling every cycle.
REQ-023 Out-of-range inputs: output values unspecified, handshake behaviour unchanged.

Reset
REQ-024 While rst_i is high, SHALL clear all stage valid bits; valid_o=0, a_o=0, b_o=0 in the cycle after.
REQ-025 SHALL discard in-flight triples when rst_i asserts mid-operation; no result emerges for them after reset.
REQ-026 SHALL keep ready_o = 1 during and immediately after reset (pipeline empty).

Structure
REQ-027 SHALL place Q, QINV, MONT (4193792 = 2^32 mod Q), DATA_WIDTH and BFLY_LATENCY (4) in shared package dili_pkg.
REQ-028 SHALL implement S3-S4 as sub-module dili_mont_reduce (64-bit in, [0,Q) out, 2 cycles, enable input), reusable by the forward butterfly.
REQ-029 SHALL keep data-path registers free of reset; only valid bits and output registers are reset.

Verification
REQ-030 a=5, b=3, zeta=4193792, ready_i=1 -> 4 cycles later a_o=8, b_o=2, valid_o pulse of 1 cycle.
REQ-031 a=8380416, b=1, zeta=4193792 -> a_o=0, b_o=8380415; a=0, b=1 -> a_o=1, b_o=8380416.
REQ-032 20 back-to-back random triples with ready_i=1 -> 20 results, in order, matching a 64-bit reference model, 1/cycle.
REQ-033 stream of 8 triples, ready_i low for 3 cycles mid-stream -> ready_o low those cycles, outputs held, all 8 results delivered in order, none duplicated.
REQ-034 3 triples in flight, rst_i high 1 cycle -> valid_o=0 next cycle, none of the 3 results ever appear, next triple after reset returns correctly after 4 cycles.

Source files
------------

// File: rtl/dili_pkg.sv
// Shared constants for the Dilithium NTT datapath: modulus, Montgomery
// constants, default coefficient width and butterfly pipeline depth.
package dili_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam logic [31:0] Q            = 32'd8380417;
    localparam logic [31:0] QINV         = 32'd58728449;
    localparam logic [31:0] MONT         = 32'd4193792;
    localparam int unsigned BFLY_LATENCY = 4;

endpackage

// File: rtl/dili_mont_reduce.sv
// Two-cycle Montgomery reduction: r = p * 2^-32 mod Q, result in [0,Q).
// Shared between the forward and inverse butterflies.
module dili_mont_reduce #(
    parameter int unsigned DATA_WIDTH = dili_pkg::DATA_WIDTH,
    parameter logic [31:0] Q          = dili_pkg::Q,
    parameter logic [31:0] QINV       = dili_pkg::QINV
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [63:0]           i_p,
    output logic [DATA_WIDTH-1:0] o_r
);
    import dili_pkg::*;

    logic [31:0]           r_t;
    logic [63:0]           r_p;
    logic [DATA_WIDTH-1:0] r_r;
    logic [63:0]           w_tq;
    logic [31:0]           w_hi;
    logic [31:0]           w_fix;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_t <= i_p[31:0] * QINV;
            r_p <= i_p;
        end
    end

    // t*Q matches p in the low 32 bits, so the shifted difference is exact
    // and lies in (-Q, Q); one conditional +Q brings it into range.
    always_comb begin
        w_tq  = 64'(r_t) * 64'(Q);
        w_hi  = 32'((r_p - w_tq) >> 32);
        w_fix = w_hi[31] ? w_hi + Q : w_hi;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_r <= '0;
        end else if (i_en) begin
            r_r <= DATA_WIDTH'(w_fix);
        end
    end

    assign o_r = r_r;

endmodule

// File: rtl/dili_gs_butterfly.sv
// Inverse-NTT Gentleman-Sande butterfly, 4-stage pipeline with a single
// global stall: a_o = a+b mod Q, b_o = (a-b)*zeta*2^-32 mod Q.
module dili_gs_butterfly #(
    parameter int unsigned DATA_WIDTH = dili_pkg::DATA_WIDTH,
    parameter logic [31:0] Q          = dili_pkg::Q,
    parameter logic [31:0] QINV       = dili_pkg::QINV
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] zeta_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o
);
    import dili_pkg::*;

    localparam logic [DATA_WIDTH:0] LQ = (DATA_WIDTH+1)'(Q);

    logic                  w_en;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sum_mod;
    logic [DATA_WIDTH-1:0] w_dif_mod;

    logic                  r_s1_v, r_s2_v, r_s3_v, r_valid_o;
    logic [DATA_WIDTH-1:0] r_s1_a, r_s1_d, r_s1_z;
    logic [DATA_WIDTH-1:0] r_s2_a, r_s3_a, r_a_o;
    logic [63:0]           r_s2_p;

    // Whole pipeline advances together whenever the output slot can move.
    assign w_en    = !r_valid_o || ready_i;
    assign ready_o = w_en;
    assign valid_o = r_valid_o;
    assign a_o     = r_a_o;

    always_comb begin
        w_sum     = {1'b0, a_i} + {1'b0, b_i};
        w_sum_mod = (w_sum >= LQ) ? DATA_WIDTH'(w_sum - LQ) : DATA_WIDTH'(w_sum);
        w_dif_mod = (a_i < b_i) ? DATA_WIDTH'({1'b0, a_i} + LQ - {1'b0, b_i})
                                : a_i - b_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s3_v    <= 1'b0;
            r_valid_o <= 1'b0;
            r_a_o     <= '0;
        end else if (w_en) begin
            r_s1_v    <= valid_i;
            r_s2_v    <= r_s1_v;
            r_s3_v    <= r_s2_v;
            r_valid_o <= r_s3_v;
            r_a_o     <= r_s3_a;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_s1_a <= w_sum_mod;
            r_s1_d <= w_dif_mod;
            r_s1_z <= zeta_i;
            r_s2_a <= r_s1_a;
            r_s2_p <= 64'(r_s1_d) * 64'(r_s1_z);
            r_s3_a <= r_s2_a;
        end
    end

    dili_mont_reduce #(
        .DATA_WIDTH(DATA_WIDTH),
        .Q         (Q),
        .QINV      (QINV)
    ) u_mont (
        .i_clk(clk_i),
        .i_rst(rst_i),
        .i_en (w_en),
        .i_p  (r_s2_p),
        .o_r  (b_o)
    );

endmodule
